// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory between two fetch stages.
// Grants are combinational; responses return one cycle later, tagged to the granted core.
module imem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              flush0,
   output logic              stall0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              flush1,
   output logic              stall1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic             last_id_q, last_id_d;
   logic             inflight_v_q, inflight_v_d;
   logic             inflight_id_q, inflight_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic elig0, elig1, gnt0, gnt1;

   // last_id_q == 1 means core 1 was served last, so core 0 wins a tie
   always_comb begin
      elig0 = req0 & ~flush0 & ~rst;
      elig1 = req1 & ~flush1 & ~rst;
      gnt0  = elig0 & (~elig1 | last_id_q);
      gnt1  = elig1 & (~elig0 | ~last_id_q);
   end

   always_comb begin
      mem_en   = gnt0 | gnt1;
      mem_addr = '0;
      if (gnt0) begin
         mem_addr = addr0;
      end else if (gnt1) begin
         mem_addr = addr1;
      end
      stall0 = elig0 & ~gnt0;
      stall1 = elig1 & ~gnt1;
   end

   // A flush in the response cycle kills the wrong-path instruction
   always_comb begin
      rvalid0 = inflight_v_q & ~inflight_id_q & ~flush0 & ~rst;
      rvalid1 = inflight_v_q &  inflight_id_q & ~flush1 & ~rst;
      rdata0  = rvalid0 ? mem_rdata : '0;
      rdata1  = rvalid1 ? mem_rdata : '0;
   end

   always_comb begin
      last_id_d     = last_id_q;
      inflight_v_d  = gnt0 | gnt1;
      inflight_id_d = gnt1;
      cnt_d         = cnt_q;
      if (gnt0 | gnt1) begin
         last_id_d = gnt1;
      end
      if (elig0 & elig1 & ~(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_id_q     <= 1'b1;
         inflight_v_q  <= 1'b0;
         inflight_id_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         last_id_q     <= last_id_d;
         inflight_v_q  <= inflight_v_d;
         inflight_id_q <= inflight_id_d;
         cnt_q         <= cnt_d;
      end
   end

   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reference arbitration model plus a response scoreboard queue.
module tb_imem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, flush0, req1, flush1;
   logic [AW-1:0] addr0, addr1;
   logic          stall0, stall1, rvalid0, rvalid1, mem_en;
   logic [DW-1:0] rdata0, rdata1, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] conflict_cnt;

   typedef struct packed {
      logic          v;
      logic          id;
      logic [DW-1:0] d;
   } resp_t;

   resp_t         sb[$];
   logic          m_last;
   logic [CW-1:0] m_cnt;
   int            n_chk = 0;
   int            n_fail = 0;

   imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .flush0(flush0), .stall0(stall0),
      .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .flush1(flush1), .stall1(stall1),
      .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // 0x0 -> 0x13, 0x4 -> 0x93, 0x8 -> 0x113
   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return (a << 5) + 32'h13;
   endfunction

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem_f(mem_addr);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r0, input logic [AW-1:0] a0, input logic f0,
                        input logic r1, input logic [AW-1:0] a1, input logic f1,
                        input logic rs);
      logic  e0, e1, g0, g1, rv0, rv1;
      resp_t rsp;
      req0 = r0; addr0 = a0; flush0 = f0;
      req1 = r1; addr1 = a1; flush1 = f1;
      rst  = rs;
      #3;
      e0 = r0 & ~f0 & ~rs;
      e1 = r1 & ~f1 & ~rs;
      g0 = e0 && (!e1 || m_last);
      g1 = e1 && !g0;
      chk("stall0", 64'(stall0), 64'(e0 & ~g0));
      chk("stall1", 64'(stall1), 64'(e1 & ~g1));
      chk("mem_en", 64'(mem_en), 64'(g0 | g1));
      chk("mem_addr", 64'(mem_addr), g0 ? 64'(a0) : (g1 ? 64'(a1) : 64'd0));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      rsp = sb.pop_front();
      rv0 = rsp.v && !rsp.id && !f0 && !rs;
      rv1 = rsp.v &&  rsp.id && !f1 && !rs;
      chk("rvalid0", 64'(rvalid0), 64'(rv0));
      chk("rvalid1", 64'(rvalid1), 64'(rv1));
      chk("rdata0", 64'(rdata0), rv0 ? 64'(rsp.d) : 64'd0);
      chk("rdata1", 64'(rdata1), rv1 ? 64'(rsp.d) : 64'd0);
      sb.push_back('{v: g0 | g1, id: g1, d: (g0 ? mem_f(a0) : mem_f(a1))});
      @(posedge clk);
      if (rs) begin
         m_last = 1'b1;
         m_cnt  = '0;
      end else begin
         if (g0 | g1) m_last = g1;
         if (e0 && e1 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
      addr0 = '0; addr1 = '0;
      m_last = 1'b1; m_cnt = '0;
      sb.push_back('{v: 1'b0, id: 1'b0, d: '0});
      @(posedge clk); #1;

      // Reset held with both requesting
      cycle(1, 32'h0, 0, 1, 32'h4, 0, 1);
      cycle(1, 32'h0, 0, 1, 32'h4, 0, 1);
      chk("cnt_after_reset", 64'(conflict_cnt), 64'd0);

      // Contention: first tie after reset goes to core 0
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            req0 = 1; addr0 = 32'h40; req1 = 1; addr1 = 32'h80; flush0 = 0; flush1 = 0; rst = 0;
            #3;
            chk("first_tie_addr", 64'(mem_addr), 64'h40);
            chk("first_tie_stall1", 64'(stall1), 64'd1);
            #1;
         end
         cycle(1, 32'h40 + 32'(i * 4), 0, 1, 32'h80 + 32'(i * 4), 0, 0);
      end
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
      chk("cnt_contention", 64'(conflict_cnt), 64'd6);

      // Core 0 only, full throughput
      cycle(1, 32'h0, 0, 0, 32'h0, 0, 0);
      cycle(1, 32'h4, 0, 0, 32'h0, 0, 0);
      cycle(1, 32'h8, 0, 0, 32'h0, 0, 0);
      #3;
      chk("rdata0_0x113", 64'(rdata0), 64'h113);
      #1;
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);

      // Flush in response cycle kills core 1 response
      cycle(0, 32'h0, 0, 1, 32'h100, 0, 0);
      cycle(0, 32'h0, 0, 0, 32'h0, 1, 0);

      // Flush with request: core 0 granted, nobody stalled, no contention
      cycle(1, 32'h20, 0, 1, 32'h200, 1, 0);
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);

      // Flush on in-flight owner while other core is granted
      cycle(0, 32'h0, 0, 1, 32'h104, 0, 0);
      cycle(1, 32'h24, 0, 1, 32'h108, 1, 0);
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);

      // Saturation
      for (int i = 0; i < 20; i++) begin
         cycle(1, 32'h300 + 32'(i * 4), 0, 1, 32'h400 + 32'(i * 4), 0, 0);
      end
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
      chk("cnt_saturated", 64'(conflict_cnt), 64'hF);

      // Reset mid-flight suppresses the pending response
      cycle(1, 32'h30, 0, 0, 32'h0, 0, 0);
      cycle(1, 32'h34, 0, 0, 32'h0, 0, 1);
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
      cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Round-robin arbiter that shares one single-port, synchronous-read instruction memory between the fetch stages of the two cores. Each core's fetch stage presents its PC as a request. The arbiter grants one core per cycle and drives the per-core `stall` that freezes the losing core's PC. It routes the memory's read data back one cycle later, tagged to the granted core, and drops responses invalidated by a branch redirect (`PCSrcE`). It also keeps a saturating contention counter for performance monitoring.

## Interface
Parameters:
- `ADDR_W`, 32, instruction address width
- `DATA_W`, 32, instruction width
- `CNT_W`, 16, width of contention counter

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req0`  in  1  core 0 fetch request
- `addr0`  in  ADDR_W  core 0 fetch address (its `PCF`)
- `flush0`  in  1  core 0 redirect (its `PCSrcE`)
- `stall0`  out  1  core 0 must hold its PC this cycle
- `rvalid0`  out  1  `rdata0` carries an instruction for core 0
- `rdata0`  out  DATA_W  instruction for core 0
- `req1`, `addr1`, `flush1`, `stall1`, `rvalid1`, `rdata1`: same meaning as the core 0 ports, for core 1
- `mem_en`  out  1  memory read enable
- `mem_addr`  out  ADDR_W  memory read address
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en`
- `conflict_cnt`  out  CNT_W  saturating count of contended cycles

## Operation
- **Eligibility:** core X is eligible when `reqX=1`, `flushX=0` and `rst=0`. A flushed request is never granted.
- **Grant (combinational):**
  - One eligible core: that core wins.
  - Two eligible cores: the core other than `last_id` wins.
- **Memory drive:** `mem_en` = any grant; `mem_addr` = winner's address, else 0.
- **Stall:** `stallX = reqX & ~flushX & ~gntX`. A flushing core is never stalled, so its PC loads the redirect target.
- **State registers:**
  - `last_id` (1 bit): loads the winner id on every grant, holds otherwise.
  - `inflight_v`, `inflight_id`: record this cycle's grant, for the response next cycle.
  - `conflict_cnt`: increments when both cores are eligible; saturates at all-ones.
- **Response (cycle after grant):**
  - `rvalidX = inflight_v & (inflight_id==X) & ~flushX`.
  - `rdataX = mem_rdata` when `rvalidX`, else 0.
  - A flush in the response cycle kills the wrong-path response.
- **Reset values:** `last_id=1` (core 0 wins the first tie), `inflight_v=0`, `conflict_cnt=0`.
- **Outputs while `rst=1`:** `stall0=stall1=0`, `rvalid0=rvalid1=0`, `rdata0=rdata1=0`, `mem_en=0`, `mem_addr=0`.
- **Boundary cases:**
  - Reset mid-operation clears `inflight_v`; the response due in the following cycle is suppressed.
  - When only one core requests, it gets a grant every cycle (full throughput), and `last_id` still updates.
  - Flush on the core that owns the in-flight response, while the other core wins a new grant, in the same cycle: the old response is killed and the new grant proceeds.

## Timing
- **Latency:** grant in cycle t, `rvalid` and `rdata` in cycle t+1. Fixed at 1 cycle, no back-pressure from the cores.
- **Combinational paths:** `stall*`, `mem_en` and `mem_addr` depend on the same-cycle `req*`/`flush*`/`addr*` and on registered `last_id`. `rvalid*`/`rdata*` depend on registered `inflight_*`, same-cycle `flush*` and `mem_rdata`.
- **Throughput under contention:** strict alternation 0,1,0,1…; each core gets one instruction every 2 cycles.
- **Single requester:** one instruction per cycle.
- **`conflict_cnt`:** updates on the edge that ends a contended cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with both `req` high -> `mem_en=0`, `stall0=stall1=0`, `rvalid*=0`, `conflict_cnt=0`. The first contended cycle after reset grants core 0.
- **Core 0 only:** `req0` held, `addr0` = 0x0, 0x4, 0x8 on consecutive cycles, memory returns 0x13, 0x93, 0x113 -> `mem_addr` follows `addr0` in the same cycle. `stall0=0` throughout. `rvalid0=1` with `rdata0` = 0x13, 0x93, 0x113 one cycle later. `rvalid1` stays 0.
- **Contention:** both `req` high for 6 cycles -> grants 0,1,0,1,0,1. `stall1=1` on core-0 cycles and `stall0=1` on core-1 cycles. `conflict_cnt=6`. Responses alternate `rvalid0`/`rvalid1`.
- **Flush in response cycle:** core 1 granted at t with `addr1=0x100`, `flush1=1` at t+1 -> `rvalid1=0` at t+1.
- **Flush with request:** `req1=flush1=1` and `req0=1` in one cycle -> core 0 granted, `stall1=0`, `stall0=0`, `conflict_cnt` unchanged.
- **Saturation and reset mid-flight:** with `CNT_W=4`, 20 contended cycles -> `conflict_cnt` holds 15. Assert `rst` in the cycle after a grant -> no `rvalid` in that cycle or the next.
